// File: rtl/axi_slave_write_engine.sv
`default_nettype none
// ============================================================================
// Module : axi_slave_write_engine
// Brief  : AXI4 slave write path with AW queue, FIXED/INCR/WRAP burst
//          sequencing onto a backend write port, and OKAY/SLVERR responses.
// Rev    : 1.0
// ============================================================================
module axi_slave_write_engine #(
    parameter int unsigned  ADDR_W    = 32,
    parameter int unsigned  DATA_W    = 32,
    parameter int unsigned  ID_W      = 12,
    parameter int unsigned  AW_DEPTH  = 2,
    parameter logic [31:0]  MEM_BASE  = 32'h0,
    parameter logic [31:0]  MEM_BYTES = 32'h1000,
    localparam int unsigned STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              s_axi_aresetn,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0] s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [STRB_W-1:0] mem_wr_strb,
    input  logic              mem_wr_ready,
    output logic              tx_wactive,
    output logic              tx_bwait
);

    localparam int unsigned       c_ptr_w    = (AW_DEPTH > 1) ? $clog2(AW_DEPTH) : 1;
    localparam int unsigned       c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(AW_DEPTH);
    localparam logic [2:0]        c_max_size = 3'($clog2(STRB_W));
    localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(MEM_BASE);
    localparam logic [ADDR_W-1:0] c_bytes    = ADDR_W'(MEM_BYTES);
    localparam logic [1:0]        c_fixed    = 2'b00;
    localparam logic [1:0]        c_incr     = 2'b01;
    localparam logic [1:0]        c_wrap     = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } aw_req_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    aw_req_t              aw_mem_q [AW_DEPTH];
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic                 awready_q, awready_d;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    logic [7:0]           beat_cnt_q, beat_cnt_d;
    logic                 err_q, err_d;

    logic                 aw_push, aw_pop;
    aw_req_t              aw_in, aw_head;
    logic [ADDR_W-1:0]    bytes, aligned, incr_addr, wrap_mask, next_addr;
    logic                 in_window, wready_int, beat, last_cnt, wr_en;

    always_comb begin
        aw_in    = '{id: s_axi_awid, addr: s_axi_awaddr, len: s_axi_awlen,
                     size: s_axi_awsize, burst: s_axi_awburst};
        aw_head  = aw_mem_q[rd_ptr_q];
        aw_push  = s_axi_awvalid & awready_q;
        aw_pop   = (state_q == S_IDLE) & (count_q != '0);
        wr_ptr_d = aw_push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
        rd_ptr_d = aw_pop  ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
        count_d  = count_q + c_cnt_w'(aw_push) - c_cnt_w'(aw_pop);
        // Registered so awready stays low through reset and rises on the first edge after it.
        awready_d = (count_d != c_depth);
    end

    always_comb begin
        bytes     = {{(ADDR_W-1){1'b0}}, 1'b1} << size_q;
        aligned   = addr_q & ~(bytes - 1'b1);
        incr_addr = aligned + bytes;
        wrap_mask = ((ADDR_W'(len_q) + 1'b1) << size_q) - 1'b1;
        unique case (burst_q)
            c_fixed: next_addr = addr_q;
            c_incr:  next_addr = incr_addr;
            c_wrap:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = addr_q;
        endcase
        in_window  = (addr_q >= c_base) && ((addr_q - c_base) < c_bytes);
        // An errored burst drains its W beats without waiting on the backend.
        wready_int = err_q | mem_wr_ready;
        beat       = (state_q == S_DATA) & s_axi_wvalid & wready_int;
        last_cnt   = (beat_cnt_q == len_q);
        wr_en      = beat & ~err_q & in_window;
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (aw_pop) begin
                    id_d       = aw_head.id;
                    addr_d     = aw_head.addr;
                    len_d      = aw_head.len;
                    size_d     = aw_head.size;
                    burst_d    = aw_head.burst;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                err_d   = (burst_q == 2'b11) || (size_q > c_max_size) ||
                          ((burst_q == c_wrap) &&
                           !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));
                state_d = S_DATA;
            end
            S_DATA: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    addr_d     = next_addr;
                    if (!in_window || (s_axi_wlast != last_cnt)) begin
                        err_d = 1'b1;
                    end
                    if (s_axi_wlast || last_cnt) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (s_axi_bready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aw_push) begin
            aw_mem_q[wr_ptr_q] <= aw_in;
        end
    end

    always_ff @(posedge clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            awready_q  <= 1'b0;
            state_q    <= S_IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            awready_q  <= awready_d;
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = (state_q == S_DATA) & wready_int;
    assign s_axi_bvalid  = (state_q == S_RESP);
    assign s_axi_bid     = (state_q == S_RESP) ? id_q : '0;
    assign s_axi_bresp   = ((state_q == S_RESP) && err_q) ? 2'b10 : 2'b00;
    assign mem_wr_en     = wr_en;
    assign mem_wr_addr   = (state_q == S_DATA) ? addr_q : '0;
    assign mem_wr_data   = (state_q == S_DATA) ? s_axi_wdata : '0;
    assign mem_wr_strb   = (state_q == S_DATA) ? s_axi_wstrb : '0;
    assign tx_wactive    = (state_q == S_DATA);
    assign tx_bwait      = (state_q == S_RESP);

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_write_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_slave_write_engine
// Brief  : Directed scoreboard bench for axi_slave_write_engine.
// Rev    : 1.0
// ============================================================================
module tb_axi_slave_write_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [11:0] bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strb;
    logic        mem_wr_ready = 1'b1;
    logic        tx_wactive;
    logic        tx_bwait;

    axi_slave_write_engine dut (
        .clk           (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awid    (awid),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_awsize  (awsize),
        .s_axi_awburst (awburst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bid     (bid),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_strb   (mem_wr_strb),
        .mem_wr_ready  (mem_wr_ready),
        .tx_wactive    (tx_wactive),
        .tx_bwait      (tx_bwait)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct packed {
        logic [11:0] id;
        logic [1:0]  resp;
    } b_t;

    wr_t exp_wq[$];
    b_t  exp_bq[$];
    wr_t mon_wgot, mon_wexp;
    b_t  mon_bgot, mon_bexp;
    int  tests = 0;
    int  fails = 0;
    logic [31:0] wrap_exp [0:3] = '{32'h10C, 32'h100, 32'h104, 32'h108};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        exp_wq.push_back('{addr: addr, data: data, strb: strb});
    endtask

    task automatic exp_b(input logic [11:0] id, input logic [1:0] resp);
        exp_bq.push_back('{id: id, resp: resp});
    endtask

    // Scoreboard: every backend write and every B handshake is matched in order.
    always @(negedge clk) begin
        if (rst_n && mem_wr_en) begin
            mon_wgot = '{addr: mem_wr_addr, data: mem_wr_data, strb: mem_wr_strb};
            tests++;
            assert (exp_wq.size() != 0) else begin
                fails++;
                $error("FAIL wr_unexpected observed=%h expected=none", mon_wgot);
            end
            if (exp_wq.size() != 0) begin
                mon_wexp = exp_wq.pop_front();
                tests++;
                assert (mon_wgot === mon_wexp) else begin
                    fails++;
                    $error("FAIL wr_beat observed=%h expected=%h", mon_wgot, mon_wexp);
                end
            end
        end
        if (rst_n && bvalid && bready) begin
            mon_bgot = '{id: bid, resp: bresp};
            tests++;
            assert (exp_bq.size() != 0) else begin
                fails++;
                $error("FAIL b_unexpected observed=%h expected=none", mon_bgot);
            end
            if (exp_bq.size() != 0) begin
                mon_bexp = exp_bq.pop_front();
                tests++;
                assert (mon_bgot === mon_bexp) else begin
                    fails++;
                    $error("FAIL b_resp observed=%h expected=%h", mon_bgot, mon_bexp);
                end
            end
        end
    end

    task automatic send_aw(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok = 1'b0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = awready;
            @(posedge clk);
            #1;
        end
        awvalid = 1'b0;
        check("aw_handshake", ok, 1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input bit last,
                          input bit chk_rdy, input bit rand_rdy);
        bit ok = 1'b0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (rand_rdy) mem_wr_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (chk_rdy && tx_wactive) check("wready_follow", wready, mem_wr_ready);
            ok = wready;
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (rand_rdy) mem_wr_ready = 1'b1;
        check("w_handshake", ok, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_bq.size() != 0; i++) @(posedge clk);
        #1;
        check("b_drain", exp_bq.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_mem_wr_en", mem_wr_en, 0);
        rst_n = 1'b1;
        #1;
        check("awready_before_edge", awready, 0);
        @(posedge clk);
        #1;
        check("awready_after_edge", awready, 1);

        // INCR 0x100 len=3 size=2
        exp_b(12'h005, 2'b00);
        send_aw(12'h005, 32'h100, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            exp_wr(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
            send_w(32'hA000_0000 + 32'(i), 4'hF, i == 3, 1'b1, 1'b0);
        end
        drain();

        // WRAP 0x10C len=3 size=2
        exp_b(12'h006, 2'b00);
        send_aw(12'h006, 32'h10C, 8'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) begin
            exp_wr(wrap_exp[i], 32'hB000_0000 + 32'(i), 4'hF);
            send_w(32'hB000_0000 + 32'(i), 4'hF, i == 3, 1'b0, 1'b0);
        end
        drain();

        // FIXED 0x20 len=1
        exp_b(12'h007, 2'b00);
        send_aw(12'h007, 32'h20, 8'd1, 3'd2, 2'b00);
        for (int i = 0; i < 2; i++) begin
            exp_wr(32'h20, 32'hC000_0000 + 32'(i), 4'h3);
            send_w(32'hC000_0000 + 32'(i), 4'h3, i == 1, 1'b0, 1'b0);
        end
        drain();

        // INCR crossing the window end: only 0xFF8 and 0xFFC are written
        exp_b(12'h008, 2'b10);
        send_aw(12'h008, 32'hFF8, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            if (i < 2) exp_wr(32'hFF8 + 32'(4 * i), 32'hD000_0000 + 32'(i), 4'hF);
            send_w(32'hD000_0000 + 32'(i), 4'hF, i == 3, 1'b0, 1'b0);
        end
        drain();

        // Early wlast on beat 2 of len=3
        exp_b(12'h009, 2'b10);
        send_aw(12'h009, 32'h200, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 2; i++) begin
            exp_wr(32'h200 + 32'(4 * i), 32'hE000_0000 + 32'(i), 4'hF);
            send_w(32'hE000_0000 + 32'(i), 4'hF, i == 1, 1'b0, 1'b0);
        end
        drain();

        // Reserved burst type: beats consumed, nothing written
        exp_b(12'h00A, 2'b10);
        send_aw(12'h00A, 32'h240, 8'd1, 3'd2, 2'b11);
        for (int i = 0; i < 2; i++) send_w(32'hF000_0000 + 32'(i), 4'hF, i == 1, 1'b0, 1'b0);
        drain();

        // awsize wider than the bus
        exp_b(12'h00B, 2'b10);
        send_aw(12'h00B, 32'h280, 8'd0, 3'd3, 2'b01);
        send_w(32'h1234_5678, 4'hF, 1'b1, 1'b0, 1'b0);
        drain();

        // WRAP with an illegal length (3 beats)
        exp_b(12'h00C, 2'b10);
        send_aw(12'h00C, 32'h2C0, 8'd2, 3'd2, 2'b10);
        for (int i = 0; i < 3; i++) send_w(32'h5555_0000 + 32'(i), 4'hF, i == 2, 1'b0, 1'b0);
        drain();

        // Three AWs back-to-back with bready low
        bready = 1'b0;
        exp_b(12'h001, 2'b00);
        exp_b(12'h002, 2'b00);
        exp_b(12'h003, 2'b00);
        send_aw(12'h001, 32'h300, 8'd0, 3'd2, 2'b01);
        send_aw(12'h002, 32'h304, 8'd0, 3'd2, 2'b01);
        send_aw(12'h003, 32'h308, 8'd0, 3'd2, 2'b01);
        @(negedge clk);
        check("aw_queue_full", awready, 0);
        @(posedge clk);
        #1;
        exp_wr(32'h300, 32'h0300_0001, 4'hF);
        send_w(32'h0300_0001, 4'hF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bvalid_hold", bvalid, 1);
            check("bid_hold", bid, 12'h001);
            check("tx_bwait", tx_bwait, 1);
            check("awready_still_full", awready, 0);
        end
        @(posedge clk);
        #1;
        bready = 1'b1;
        exp_wr(32'h304, 32'h0300_0002, 4'hF);
        send_w(32'h0300_0002, 4'hF, 1'b1, 1'b0, 1'b0);
        exp_wr(32'h308, 32'h0300_0003, 4'hF);
        send_w(32'h0300_0003, 4'hF, 1'b1, 1'b0, 1'b0);
        drain();

        // Backend ready toggling
        exp_b(12'h00D, 2'b00);
        send_aw(12'h00D, 32'h400, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 8; i++) begin
            exp_wr(32'h400 + 32'(4 * i), 32'h0400_0000 + 32'(i), 4'hF);
            send_w(32'h0400_0000 + 32'(i), 4'hF, i == 7, 1'b1, 1'b1);
        end
        drain();

        // Reset pulsed mid-burst: no B for the dropped burst
        send_aw(12'h00E, 32'h500, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 2; i++) begin
            exp_wr(32'h500 + 32'(4 * i), 32'h0500_0000 + 32'(i), 4'hF);
            send_w(32'h0500_0000 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        check("pre_reset_wactive", tx_wactive, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_awready", awready, 0);
        check("midrst_wready", wready, 0);
        check("midrst_bvalid", bvalid, 0);
        check("midrst_wactive", tx_wactive, 0);
        check("midrst_bwait", tx_bwait, 0);
        check("midrst_addr", mem_wr_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_awready", awready, 1);
        repeat (5) @(posedge clk);
        #1;
        check("no_stray_b", bvalid, 0);

        // Recovery burst after reset
        exp_b(12'h00F, 2'b00);
        send_aw(12'h00F, 32'h40, 8'd0, 3'd2, 2'b01);
        exp_wr(32'h40, 32'h0040_0040, 4'hA);
        send_w(32'h0040_0040, 4'hA, 1'b1, 1'b0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        #1;
        check("wq_empty", exp_wq.size(), 0);
        check("bq_empty", exp_bq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
